multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control unit for the multicycle MIPS datapath: Moore FSM decoding op[5:0] into per-cycle datapath
//  controls, including the 2-bit alu_op consumed by the ALU control decoder. Sits between the IR opcode
//  field and the datapath muxes/enables. Stalls on a memory ready handshake; optional memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready in a memory state before abort; 0 = never time out
// PORTS
//  clk          in   1  single clock, all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  op           in   6  opcode from IR[31:26]; IR is held stable from DECODE until next FETCH completes
//  zero         in   1  ALU zero flag (BEQ compare result)
//  mem_ready    in   1  memory completes current access this cycle
//  mem_req      out  1  memory access request (FETCH, MEMRD, MEMWR)
//  mem_write    out  1  write strobe, valid with mem_req
//  iord         out  1  memory address mux: 0=PC, 1=ALUOut
//  ir_write     out  1  load IR
//  pc_write     out  1  unconditional PC write
//  branch       out  1  conditional PC write qualifier
//  pc_en        out  1  pc_write | (branch & zero)
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alu_src_a    out  1  0=PC, 1=reg A
//  alu_src_b    out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op       out  2  00=add, 01=sub, 10=decode funct
//  reg_write    out  1  register file write enable
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=MDR
//  instr_done   out  1  1-cycle pulse in final state of each completed instruction
//  illegal_op   out  1  sticky: unsupported opcode decoded; cleared only by rst
//  bus_err      out  1  sticky: memory timeout occurred; cleared only by rst
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  - rst high: next state FETCH, timer 0, stickies 0. While rst high all enables (mem_req, mem_write,
//    ir_write, pc_write, branch, pc_en, reg_write, instr_done) forced 0; muxes 0, alu_op=00.
//  - Outputs are decoded from state only (plus zero for pc_en, mem_ready for FETCH writes).
//  - FETCH(0): mem_req, iord=0, srcA=0, srcB=01, alu_op=00, pc_src=00; hold until mem_ready;
//    on mem_ready: ir_write=1, pc_write=1 that cycle only -> DECODE.
//  - DECODE(1): srcA=0, srcB=11, alu_op=00. op 23h/2Bh->MEMADR, 00h->EXEC, 04h->BRANCH,
//    08h->ADDIEX, 02h->JUMP, other->FETCH and set illegal_op (no instr_done).
//  - MEMADR(2): srcA=1, srcB=10, alu_op=00; ->MEMRD if op=23h else MEMWR.
//  - MEMRD(3): mem_req, iord=1; hold until mem_ready -> MEMWB.
//  - MEMWB(4): reg_write, reg_dst=0, mem_to_reg=1, instr_done -> FETCH.
//  - MEMWR(5): mem_req, mem_write, iord=1; on mem_ready: instr_done -> FETCH.
//  - EXEC(6): srcA=1, srcB=00, alu_op=10 -> ALUWB(7): reg_write, reg_dst=1, instr_done -> FETCH.
//  - BRANCH(8): srcA=1, srcB=00, alu_op=01, pc_src=01, branch=1, instr_done -> FETCH.
//  - ADDIEX(9): srcA=1, srcB=10, alu_op=00 -> ADDIWB(10): reg_write, reg_dst=0, instr_done -> FETCH.
//  - JUMP(11): pc_src=10, pc_write=1, instr_done -> FETCH. Encodings 12-15 unreachable -> FETCH.
//  - Timer: clears on entry to any mem_req state; increments each cycle mem_req & !mem_ready; saturates.
//    When count reaches MEM_TIMEOUT (MEM_TIMEOUT>0) with mem_ready low: bus_err<=1, ->FETCH, no writes,
//    no instr_done. mem_ready high in the same cycle wins (normal completion).
//  - FETCH timeout returns to FETCH (retry) with timer cleared; bus_err stays set.
//  - Single-cycle instr counts (mem_ready always 1): LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: opcode constants, state enumeration (4-bit), alu_op codes (00/01/10),
//    alu_src_b and pc_src mux codes; also used by the ALU control decoder and datapath.
//  - One sub-module: mem_wait_timer (clear, count-enable, MEM_TIMEOUT param, expired flag).
//  - Top: state register, next-state logic, Moore output decode, sticky flags.
// TESTING
//  - rst 3 cycles while in MEMRD -> all enables 0 during rst, state_dbg=0 after, illegal_op=bus_err=0.
//  - op=23h, mem_ready=1 -> states 0,1,2,3,4,0; reg_write+mem_to_reg only in state 4; 1 instr_done.
//  - op=04h zero=1 -> pc_en=1, pc_src=01, alu_op=01 in BRANCH; zero=0 -> pc_en=0.
//  - op=00h, mem_ready low 3 cycles in FETCH -> FETCH held 4 cycles; ir_write, pc_write 1 cycle each.
//  - op=3Fh -> DECODE->FETCH, illegal_op=1 held across later legal instrs until rst.
//  - MEM_TIMEOUT=4, op=2Bh, mem_ready=0 -> 4 cycles in MEMWR, bus_err=1, FETCH, no instr_done.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the multicycle MIPS datapath.
// The main FSM, the ALU control decoder and the datapath all import this package.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory access; expired fires on the cycle the
// count reaches MEM_TIMEOUT while still stalled. MEM_TIMEOUT=0 never expires.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (cnt_en && (count_q != '1)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // This cycle's increment is the one that reaches the limit.
  assign expired = (MEM_TIMEOUT != 0) && cnt_en &&
                   ((32'(count_q) + 32'd1) >= MEM_TIMEOUT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control unit for the multicycle MIPS datapath: state register,
// next-state logic, state-decoded datapath controls and sticky error flags.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   tmo;
  logic   stall;
  ctrl_t  ctrl;

  assign stall = ctrl.mem_req & ~mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_d != state_q) | tmo),
    .cnt_en  (stall),
    .expired (tmo)
  );

  // Next state and sticky flag updates.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (tmo) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b1;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Moore decode; only FETCH writes and MEMWR completion look at mem_ready.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_BOFS;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (rst) ctrl = '0;
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign branch     = ctrl.branch;
  assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = illegal_q;
  assign bus_err    = bus_err_q;
  assign state_dbg  = state_q;

endmodule
